// File: rtl/fifo_level.sv
// ============================================================================
//  Module      : fifo_level
//  Description : First-word-fall-through circular FIFO with occupancy count,
//                programmable almost-full/almost-empty thresholds and optional
//                sticky overflow/underflow flags (enabled by FIFO_LEVEL_ERR_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_level #(
    parameter int WORD_BITS     = 8,
    parameter int ADDR_BITS     = 4,
    parameter int AFULL_THRESH  = 2**ADDR_BITS - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 almost_full,
    output logic                 almost_empty,
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int               DEPTH    = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] c_DEPTH  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] c_AFULL  = (ADDR_BITS+1)'(AFULL_THRESH);
    localparam logic [ADDR_BITS:0] c_AEMPTY = (ADDR_BITS+1)'(AEMPTY_THRESH);

    logic [WORD_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wptr;
    logic [ADDR_BITS-1:0] r_rptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_afull;
    logic                 r_aempty;

    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [ADDR_BITS:0]   w_count_next;

    // A write while full is still accepted when a read frees the head slot.
    assign w_wr_ok      = write & (~r_full | read);
    assign w_rd_ok      = read & ~r_empty;
    assign w_count_next = r_count + (ADDR_BITS+1)'(w_wr_ok) - (ADDR_BITS+1)'(w_rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ADDR_BITS'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + ADDR_BITS'(1);
            end
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_full   <= (w_count_next == c_DEPTH);
            r_afull  <= (w_count_next >= c_AFULL);
            r_aempty <= (w_count_next <= c_AEMPTY);
        end
    end

    // Storage is deliberately left out of reset; stale words are never visible.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    assign rdata        = r_mem[r_rptr];
    assign empty        = r_empty;
    assign full         = r_full;
    assign count        = r_count;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;

`ifdef FIFO_LEVEL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A set event in the same cycle as err_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write & r_full & ~read) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (read & r_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: a vector table for basic push/pop, then
// hand-written sequences for the full/empty/wrap/reset corner cases.
`default_nettype none

module tb_fifo_level;

`ifdef FIFO_LEVEL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;
    localparam int AEMPTY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       empty, full, almost_full, almost_empty;
    logic [4:0] count;
    logic       err_clr = 1'b0;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ov = 1'b0;
    bit         m_uf = 1'b0;

    fifo_level dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .write        (write),
        .wdata        (wdata),
        .rdata        (rdata),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rd;
        logic       wr;
        logic       clr;
        logic [7:0] wd;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ae;
        logic       uf;
        logic       chk_rd;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-based reference: pop (if any) then push, following the accept rules.
    task automatic do_op(input logic rst, input logic rd, input logic wr,
                         input logic clr, input logic [7:0] d);
        bit wr_ok, rd_ok, ov_set, uf_set;
        reset = rst; read = rd; write = wr; err_clr = clr; wdata = d;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ov = 1'b0;
            m_uf = 1'b0;
        end else begin
            wr_ok  = wr && (q.size() < DEPTH || rd);
            rd_ok  = rd && (q.size() > 0);
            ov_set = wr && (q.size() == DEPTH) && !rd;
            uf_set = rd && (q.size() == 0);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
            m_ov = ov_set ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_uf = uf_set ? 1'b1 : (clr ? 1'b0 : m_uf);
        end
        chk("m_count",  32'(count),        32'(q.size()));
        chk("m_empty",  32'(empty),        32'(q.size() == 0));
        chk("m_full",   32'(full),         32'(q.size() == DEPTH));
        chk("m_afull",  32'(almost_full),  32'(q.size() >= AFULL));
        chk("m_aempty", 32'(almost_empty), 32'(q.size() <= AEMPTY));
        chk("m_ovf",    32'(overflow),     32'(m_ov & ERR));
        chk("m_udf",    32'(underflow),    32'(m_uf & ERR));
        if (q.size() > 0) chk("m_rdata", 32'(rdata), 32'(q[0]));
    endtask

    initial begin
        //           rst rd wr clr wd     cnt emp ful af ae uf   chk rdat
        tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 1'b0, 0, 8'h00};
        tbl[1] = '{0, 0, 1, 0, 8'hA1, 1, 0, 0, 0, 1, 1'b0, 1, 8'hA1};
        tbl[2] = '{0, 0, 1, 0, 8'hB2, 2, 0, 0, 0, 1, 1'b0, 1, 8'hA1};
        tbl[3] = '{0, 0, 1, 0, 8'hC3, 3, 0, 0, 0, 0, 1'b0, 1, 8'hA1};
        tbl[4] = '{0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 1, 1'b0, 1, 8'hB2};
        tbl[5] = '{0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1'b0, 1, 8'hC3};
        tbl[6] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 1'b0, 0, 8'h00};
        tbl[7] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, ERR,  0, 8'h00};
        tbl[8] = '{0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 1'b0, 0, 8'h00};

        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst; read = tbl[i].rd; write = tbl[i].wr;
            err_clr = tbl[i].clr; wdata = tbl[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i),  32'(count),        32'(tbl[i].cnt));
            chk($sformatf("v%0d_empty", i),  32'(empty),        32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i),   32'(full),         32'(tbl[i].ful));
            chk($sformatf("v%0d_afull", i),  32'(almost_full),  32'(tbl[i].af));
            chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("v%0d_udf", i),    32'(underflow),    32'(tbl[i].uf));
            chk($sformatf("v%0d_ovf", i),    32'(overflow),     32'(0));
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdat));
        end
        q.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;

        // Fill to full, overflow attempt, simultaneous read+write at full, drain.
        for (int i = 0; i < 16; i++) do_op(0, 0, 1, 0, 8'(i));
        chk("fill_count", 32'(count), 32'(16));
        chk("fill_full",  32'(full),  32'(1));
        do_op(0, 0, 1, 0, 8'hFF);
        chk("ovf_count", 32'(count),    32'(16));
        chk("ovf_flag",  32'(overflow), 32'(ERR));
        chk("head_00",   32'(rdata),    32'(8'h00));
        do_op(0, 1, 1, 0, 8'h55);
        chk("rwfull_count", 32'(count), 32'(16));
        chk("rwfull_full",  32'(full),  32'(1));
        chk("rwfull_head",  32'(rdata), 32'(8'h01));
        for (int i = 0; i < 15; i++) do_op(0, 1, 0, 0, 8'h00);
        chk("last_word", 32'(rdata), 32'(8'h55));
        do_op(0, 1, 0, 0, 8'h00);
        chk("drained_empty", 32'(empty), 32'(1));
        do_op(0, 0, 0, 1, 8'h00);
        chk("ovf_cleared", 32'(overflow), 32'(0));

        // Simultaneous read+write while empty.
        do_op(0, 1, 1, 0, 8'h33);
        chk("rwempty_count", 32'(count),     32'(1));
        chk("rwempty_empty", 32'(empty),     32'(0));
        chk("rwempty_rdata", 32'(rdata),     32'(8'h33));
        chk("rwempty_udf",   32'(underflow), 32'(ERR));
        do_op(0, 1, 0, 1, 8'h00);

        // Interleaved traffic, pointers wrap past the end of the buffer.
        for (int i = 0; i < 5; i++)  do_op(0, 0, 1, 0, 8'(8'h60 + i));
        for (int i = 5; i < 15; i++) do_op(0, 1, 1, 0, 8'(8'h60 + i));
        for (int i = 15; i < 20; i++) do_op(0, 0, 1, 0, 8'(8'h60 + i));
        chk("wrap_count", 32'(count), 32'(10));
        for (int i = 0; i < 10; i++) do_op(0, 1, 0, 0, 8'h00);
        chk("wrap_empty", 32'(empty), 32'(1));

        // Reset mid-stream with a write pending in the reset cycle.
        for (int i = 0; i < 7; i++) do_op(0, 0, 1, 0, 8'(8'h80 + i));
        do_op(0, 1, 0, 0, 8'h00);
        do_op(1, 0, 1, 0, 8'hEE);
        chk("rst_count",  32'(count),        32'(0));
        chk("rst_empty",  32'(empty),        32'(1));
        chk("rst_aempty", 32'(almost_empty), 32'(1));
        chk("rst_udf",    32'(underflow),    32'(0));
        do_op(0, 0, 1, 0, 8'h9C);
        chk("post_rst_rdata", 32'(rdata), 32'(8'h9C));
        chk("post_rst_count", 32'(count), 32'(1));
        do_op(0, 0, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
